cic_decimate: RTL

Three-stage CIC decimator, the receive-side counterpart of the interpolating CIC. It consumes the interpolator's 23-bit signed output samples, qualified by a sample strobe, and decimates by `R`. It produces rounded or truncated `OUT_W`-bit samples with a one-cycle valid pulse. It closes the loopback chain of tone generator, interpolator and decimator, so the recovered tone can be checked against the source.

---
 rtl/cic_decimate.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cic_decimate.sv
// Three-stage CIC decimator (M=1) taking IN_W-bit samples on a strobe and emitting OUT_W-bit samples every R strobes.
// Optional build macro CIC_DEC_ROUND_EN selects round-half-up with saturation; otherwise the output is truncated.
module cic_decimate #(
    parameter int IN_W  = 23,
    parameter int R     = 4,
    parameter int OUT_W = 16
) (
    input  logic                    sclk,
    input  logic                    rst_n,
    input  logic signed [IN_W-1:0]  data_in,
    input  logic                    data_v,
    output logic signed [OUT_W-1:0] data_out,
    output logic                    data_out_v
);

    localparam int LOG2R = $clog2(R);
    localparam int W     = IN_W + 3 * LOG2R;
    localparam int SH    = W - OUT_W;
    localparam int CW    = (LOG2R > 0) ? LOG2R : 1;

`ifdef CIC_DEC_ROUND_EN
    localparam logic signed [W:0] HALF    = (W+1)'(((64'sd1 <<< SH) >>> 1));
    localparam logic signed [W:0] OUT_MAX = (W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);

    // Only the positive end can exceed the output range after adding the half LSB.
    function automatic logic signed [OUT_W-1:0] reduce_out(input logic signed [W-1:0] c);
        logic signed [W:0] sum;
        logic signed [W:0] shifted;
        sum     = $signed({c[W-1], c}) + HALF;
        shifted = sum >>> SH;
        return (shifted > OUT_MAX) ? OUT_W'(OUT_MAX) : OUT_W'(shifted);
    endfunction
`else
    function automatic logic signed [OUT_W-1:0] reduce_out(input logic signed [W-1:0] c);
        return OUT_W'(c >>> SH);
    endfunction
`endif

    logic signed [W-1:0]     din_ext_s;
    logic signed [W-1:0]     i1_r;
    logic signed [W-1:0]     i2_r;
    logic signed [W-1:0]     i3_r;
    logic [CW-1:0]           cnt_r;
    logic                    dec_r;
    logic signed [W-1:0]     d_r;
    logic signed [W-1:0]     d_prev_r;
    logic                    dv_r;
    logic signed [W-1:0]     c1_r;
    logic signed [W-1:0]     c1_prev_r;
    logic                    c1_v_r;
    logic signed [W-1:0]     c2_r;
    logic signed [W-1:0]     c2_prev_r;
    logic                    c2_v_r;
    logic signed [W-1:0]     c3_r;
    logic                    c3_v_r;
    logic signed [OUT_W-1:0] out_s;

    assign din_ext_s = {{(W-IN_W){data_in[IN_W-1]}}, data_in};

    // Integrators and decimation counter; each stage adds the previous-cycle value of the stage before it.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            i1_r  <= '0;
            i2_r  <= '0;
            i3_r  <= '0;
            cnt_r <= '0;
            dec_r <= 1'b0;
        end else if (data_v) begin
            i1_r  <= i1_r + din_ext_s;
            i2_r  <= i2_r + i1_r;
            i3_r  <= i3_r + i2_r;
            cnt_r <= cnt_r + CW'(1);
            dec_r <= (cnt_r == CW'(R - 1));
        end else begin
            dec_r <= 1'b0;
        end
    end

    // Decimation register samples the freshly updated third integrator.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            d_r  <= '0;
            dv_r <= 1'b0;
        end else if (dec_r) begin
            d_r  <= i3_r;
            dv_r <= 1'b1;
        end else begin
            dv_r <= 1'b0;
        end
    end

    // First comb stage.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            c1_r     <= '0;
            d_prev_r <= '0;
            c1_v_r   <= 1'b0;
        end else if (dv_r) begin
            c1_r     <= d_r - d_prev_r;
            d_prev_r <= d_r;
            c1_v_r   <= 1'b1;
        end else begin
            c1_v_r   <= 1'b0;
        end
    end

    // Second comb stage.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            c2_r      <= '0;
            c1_prev_r <= '0;
            c2_v_r    <= 1'b0;
        end else if (c1_v_r) begin
            c2_r      <= c1_r - c1_prev_r;
            c1_prev_r <= c1_r;
            c2_v_r    <= 1'b1;
        end else begin
            c2_v_r    <= 1'b0;
        end
    end

    // Third comb stage.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            c3_r      <= '0;
            c2_prev_r <= '0;
            c3_v_r    <= 1'b0;
        end else if (c2_v_r) begin
            c3_r      <= c2_r - c2_prev_r;
            c2_prev_r <= c2_r;
            c3_v_r    <= 1'b1;
        end else begin
            c3_v_r    <= 1'b0;
        end
    end

    // Width reduction of the comb result.
    always_comb begin
        out_s = reduce_out(c3_r);
    end

    // Output register; data_out holds between pulses.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_out_v <= 1'b0;
        end else if (c3_v_r) begin
            data_out   <= out_s;
            data_out_v <= 1'b1;
        end else begin
            data_out_v <= 1'b0;
        end
    end

endmodule
